mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit. It sits directly upstream of the load-extension stage (Loadcontrol).
//  It turns MemRead/MemWrite/funct3/address from the EX/MEM register into a req/gnt/rvalid data-memory

---
 rtl/riscv_mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   mau_state_t : access FSM states
//   F3_*        : funct3 encodings for load/store size and sign
//   f3_legal()  : size/alignment legality of an access
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mau_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; halfwords need even addresses
    // and words need 4-byte alignment.
    function automatic logic f3_legal(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = ~is_store;
            F3_H:    ok = ~addr_lo[0];
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling between the pipeline and the 32-bit data port.
//   size          in  2   funct3[1:0]: 00 byte, 01 half, 10 word
//   is_store      in  1   1 = store, 0 = load
//   addr_lo       in  2   byte offset of the current access
//   store_data    in  32  store value right-aligned in lane 0
//   rd_offset     in  2   byte offset captured for the outstanding load
//   rdata         in  32  raw read word from memory
//   be            out 4   byte enables (all lanes for loads)
//   wdata         out 32  store data replicated across the lanes
//   rdata_aligned out 32  read word shifted down so the addressed byte is lane 0
module mem_lane_align (
    input  logic [1:0]  size,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_aligned
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned; otherwise synthesis infers a latch.
        be    = 4'b1111;
        wdata = store_data;
        if (is_store) begin
            case (size)
                2'b00: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be    = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Downstream extension only slices the low bits, so the addressed byte
    // (or halfword) must land in lane 0.
    assign rdata_aligned = rdata >> {rd_offset, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: converts MemRead/MemWrite/funct3/Addr
// into a req/gnt/rvalid transaction, stalls the pipeline until it retires,
// and returns right-aligned load data for the load-extension stage.
//   clk, rst_n                    clock, asynchronous active-low reset
//   MemRead, MemWrite, funct3     access request from EX/MEM (read wins if both)
//   Addr, StoreData               byte address and lane-0 store value
//   dmem_req/we/addr/wdata/be     request side of the memory port
//   dmem_gnt/rvalid/rdata         response side of the memory port
//   Stall                         freeze IF..MEM while an access is in flight
//   LoadData, LoadValid           aligned read word and its 1-cycle strobe
//   Misaligned, Timeout           1-cycle rejection / abort indications
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       StoreData,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              Stall,
    output logic [31:0]       LoadData,
    output logic              LoadValid,
    output logic              Misaligned,
    output logic              Timeout
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    mau_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [1:0]        r_offset;
    logic [31:0]       r_load_data;
    logic              r_load_valid;
    logic              r_timeout;

    logic              w_access;
    logic              w_is_store;
    logic              w_legal;
    logic              w_idle;
    logic              w_accept;
    logic              w_in_flight;
    logic              w_complete;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata_aligned;

    assign w_access    = MemRead | MemWrite;
    assign w_is_store  = MemWrite & ~MemRead;
    assign w_legal     = f3_legal(w_is_store, funct3, Addr[1:0]);
    assign w_idle      = (r_state == IDLE);
    assign w_accept    = w_idle & w_access & w_legal;
    assign w_in_flight = (r_state == REQ) | (r_state == WAIT);
    // A store retires on grant; a load needs its data, which may arrive
    // together with the grant.
    assign w_complete  = ((r_state == REQ) & dmem_gnt & (r_we | dmem_rvalid))
                       | ((r_state == WAIT) & dmem_rvalid);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    mem_lane_align u_lane_align (
        .size          (funct3[1:0]),
        .is_store      (w_is_store),
        .addr_lo       (Addr[1:0]),
        .store_data    (StoreData),
        .rd_offset     (r_offset),
        .rdata         (dmem_rdata),
        .be            (w_be),
        .wdata         (w_wdata),
        .rdata_aligned (w_rdata_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0;
            r_offset     <= 2'b00;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            r_load_valid <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= {Addr[ADDR_W-1:2], 2'b00};
                        r_we     <= w_is_store;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_offset <= Addr[1:0];
                        r_cnt    <= '0;
                        r_state  <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // Data arriving on the last allowed cycle beats the abort.
                    if (w_complete) begin
                        if (!r_we) begin
                            r_load_data  <= w_rdata_aligned;
                            r_load_valid <= 1'b1;
                        end
                        r_state <= DONE;
                    end else if (w_cnt_inc == CNT_LIMIT) begin
                        r_timeout   <= 1'b1;
                        r_load_data <= 32'h0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if ((r_state == REQ) && dmem_gnt) begin
                            r_state <= WAIT;
                        end
                    end
                end
                // One unstalled cycle lets the retiring instruction leave MEM
                // before anything new can be accepted.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_req   = (r_state == REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign LoadData   = r_load_data;
    assign LoadValid  = r_load_valid;
    assign Timeout    = r_timeout;

    // The combinational terms look at live pipeline inputs, so they are
    // qualified with rst_n to keep every output low while reset is held.
    assign Stall      = (rst_n & w_accept) | w_in_flight;
    assign Misaligned = rst_n & w_idle & w_access & ~w_legal;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 16;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        Misaligned;
    logic        Timeout;

    mem_access_unit #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .funct3      (funct3),
        .Addr        (Addr),
        .StoreData   (StoreData),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .Stall       (Stall),
        .LoadData    (LoadData),
        .LoadValid   (LoadValid),
        .Misaligned  (Misaligned),
        .Timeout     (Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] ld_q[$];

    int checks = 0;
    int errors = 0;

    int          stall_cyc;
    int          req_cyc;
    int          lv_cyc;
    int          to_cyc;
    int          mis_cyc;
    logic [31:0] ev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model of the downstream Loadcontrol extender.
    function automatic logic [31:0] lc_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F_B:     return {{24{d[7]}}, d[7:0]};
            F_H:     return {{16{d[15]}}, d[15:0]};
            F_BU:    return {24'h0, d[7:0]};
            F_HU:    return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input logic chk_wd);
        bus_exp_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.chk_wdata = chk_wd;
        bus_q.push_back(e);
    endtask

    // Presents one instruction in MEM and plays the memory: grant in REQ
    // cycle gnt_dly+1; rvalid with the grant (rv_dly=0), in WAIT cycle rv_dly
    // (rv_dly>0), or never (rv_dly<0). Returns when the instruction leaves MEM.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int gnt_dly,
                             input int rv_dly, input logic [31:0] rdata);
        int       req_n;
        int       wait_n;
        bit       granted;
        bit       ended;
        bus_exp_t e;
        req_n = 0; wait_n = 0; granted = 0; ended = 0;
        stall_cyc = 0; req_cyc = 0; lv_cyc = 0; to_cyc = 0; mis_cyc = 0;
        ev_data = 32'hxxxx_xxxx;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; Addr = a; StoreData = sd;
        for (int cyc = 0; cyc < TO + 20; cyc++) begin
            #1;
            if (Stall) stall_cyc++;
            if (dmem_req) req_cyc++;
            if (Misaligned) mis_cyc++;
            if (Timeout) begin
                to_cyc++;
                ev_data = LoadData;
            end
            if (LoadValid) begin
                lv_cyc++;
                ev_data = LoadData;
                if (ld_q.size() == 0) check({tag, "_unexpected_loadvalid"}, 1, 0);
                else check({tag, "_loaddata"}, LoadData, ld_q.pop_front());
            end
            if (!Stall) begin
                ended = 1;
                break;
            end
            if (dmem_req && !granted) begin
                req_n++;
                if (req_n > gnt_dly) begin
                    granted  = 1;
                    dmem_gnt = 1'b1;
                    if (bus_q.size() == 0) check({tag, "_unexpected_req"}, 1, 0);
                    else begin
                        e = bus_q.pop_front();
                        check({tag, "_addr"}, dmem_addr, e.addr);
                        check({tag, "_we"}, dmem_we, e.we);
                        check({tag, "_be"}, dmem_be, e.be);
                        if (e.chk_wdata) check({tag, "_wdata"}, dmem_wdata, e.wdata);
                    end
                    if (rd && rv_dly == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = rdata;
                    end
                end
            end else if (granted && rd && !dmem_req) begin
                wait_n++;
                if (rv_dly > 0 && wait_n == rv_dly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
        end
        if (!ended) check({tag, "_completed_in_budget"}, 0, 1);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        Addr = 32'h0; StoreData = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_req", dmem_req, 0);
        check("rst_stall", Stall, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_be", dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_loaddata", LoadData, 0);
        check("rst_flags", {LoadValid, Misaligned, Timeout}, 0);

        // SW, grant in the second REQ cycle.
        push_bus(32'h100, 1'b1, 4'b1111, 32'hA1B2C3D4, 1'b1);
        do_access("sw", 1'b0, 1'b1, F_W, 32'h100, 32'hA1B2C3D4, 1, -1, 32'h0);
        check("sw_stall_cycles", stall_cyc, 3);
        check("sw_req_cycles", req_cyc, 2);
        check("sw_flags", {lv_cyc[0], to_cyc[0], mis_cyc[0]}, 0);

        // SB to the top lane.
        push_bus(32'h100, 1'b1, 4'b1000, 32'hEEEEEEEE, 1'b1);
        do_access("sb", 1'b0, 1'b1, F_B, 32'h103, 32'h000000EE, 0, -1, 32'h0);
        check("sb_stall_cycles", stall_cyc, 2);

        // SH to the upper halfword.
        push_bus(32'h100, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b1);
        do_access("sh", 1'b0, 1'b1, F_H, 32'h102, 32'h1234BEEF, 0, -1, 32'h0);
        check("sh_stall_cycles", stall_cyc, 2);

        // LBU with data on the grant cycle.
        push_bus(32'h200, 1'b0, 4'b1111, 32'h0, 1'b0);
        ld_q.push_back(32'h00001122);
        do_access("lbu", 1'b1, 1'b0, F_BU, 32'h202, 32'h0, 0, 0, 32'h11223344);
        check("lbu_stall_cycles", stall_cyc, 2);
        check("lbu_loadvalid_cycles", lv_cyc, 1);
        check("lbu_loadcontrol", lc_ext(F_BU, ev_data), 32'h00000022);
        #1;
        check("lbu_loadvalid_drops", LoadValid, 0);
        check("lbu_loaddata_held", LoadData, 32'h00001122);

        // LH with data two WAIT cycles after the grant.
        push_bus(32'h100, 1'b0, 4'b1111, 32'h0, 1'b0);
        ld_q.push_back(32'h00008001);
        do_access("lh", 1'b1, 1'b0, F_H, 32'h102, 32'h0, 0, 2, 32'h80017FFF);
        check("lh_stall_cycles", stall_cyc, 4);
        check("lh_loadcontrol", lc_ext(F_H, ev_data), 32'hFFFF8001);

        // MemRead and MemWrite together: performed as a load.
        push_bus(32'h104, 1'b0, 4'b1111, 32'h0, 1'b0);
        ld_q.push_back(32'h55AA55AA);
        do_access("rdwr", 1'b1, 1'b1, F_W, 32'h104, 32'hDEADBEEF, 0, 1, 32'h55AA55AA);
        check("rdwr_stall_cycles", stall_cyc, 3);
        check("rdwr_loadvalid_cycles", lv_cyc, 1);

        // Rejected accesses: no request, no stall, one-cycle Misaligned.
        do_access("lw_mis", 1'b1, 1'b0, F_W, 32'h102, 32'h0, 0, -1, 32'h0);
        check("lw_mis_pulse", mis_cyc, 1);
        check("lw_mis_stall", stall_cyc, 0);
        #1;
        check("lw_mis_no_req", dmem_req, 0);
        check("lw_mis_clears", Misaligned, 0);
        do_access("sh_mis", 1'b0, 1'b1, F_H, 32'h101, 32'h0, 0, -1, 32'h0);
        check("sh_mis_pulse", mis_cyc, 1);
        #1;
        check("sh_mis_no_req", dmem_req, 0);
        do_access("sbu_ill", 1'b0, 1'b1, F_BU, 32'h100, 32'h0, 0, -1, 32'h0);
        check("sbu_ill_pulse", mis_cyc, 1);
        do_access("ld011_ill", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, -1, 32'h0);
        check("ld011_ill_pulse", mis_cyc, 1);
        check("ld011_ill_req", req_cyc, 0);

        // LH granted but never answered: abort after TO REQ+WAIT cycles.
        push_bus(32'h104, 1'b0, 4'b1111, 32'h0, 1'b0);
        do_access("to", 1'b1, 1'b0, F_H, 32'h104, 32'h0, 0, -1, 32'h0);
        check("to_pulse", to_cyc, 1);
        check("to_loaddata", ev_data, 0);
        check("to_stall_cycles", stall_cyc, TO + 1);
        check("to_no_loadvalid", lv_cyc, 0);
        check("to_req_cycles", req_cyc, 1);

        // Data on the final allowed cycle wins over the abort.
        push_bus(32'h108, 1'b0, 4'b1111, 32'h0, 1'b0);
        ld_q.push_back(32'hCAFEF00D);
        do_access("to_prio", 1'b1, 1'b0, F_W, 32'h108, 32'h0, 0, TO - 1, 32'hCAFEF00D);
        check("to_prio_no_timeout", to_cyc, 0);
        check("to_prio_loadvalid", lv_cyc, 1);
        check("to_prio_stall_cycles", stall_cyc, TO + 1);

        // Reset asserted while a load waits for data.
        @(negedge clk);
        MemRead = 1'b1; funct3 = F_W; Addr = 32'h300;
        @(negedge clk); #1;
        check("rstw_req", dmem_req, 1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("rstw_wait_stall", Stall, 1);
        check("rstw_wait_no_req", dmem_req, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_req0", dmem_req, 0);
        check("rstw_stall0", Stall, 0);
        check("rstw_addr0", dmem_addr, 0);
        check("rstw_be0", dmem_be, 0);
        check("rstw_loaddata0", LoadData, 0);
        check("rstw_flags0", {dmem_we, LoadValid, Misaligned, Timeout}, 0);
        @(negedge clk);
        MemRead = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        #1;
        check("late_rvalid_no_loadvalid", LoadValid, 0);
        check("late_rvalid_loaddata", LoadData, 0);
        check("late_rvalid_idle", {dmem_req, Stall}, 0);

        // Normal operation resumes after the reset.
        push_bus(32'h300, 1'b0, 4'b1111, 32'h0, 1'b0);
        ld_q.push_back(32'h00000080);
        do_access("lb_after_rst", 1'b1, 1'b0, F_B, 32'h301, 32'h0, 0, 1, 32'h000080FF);
        check("lb_after_rst_loadcontrol", lc_ext(F_B, ev_data), 32'hFFFFFF80);

        check("bus_queue_drained", bus_q.size(), 0);
        check("load_queue_drained", ld_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
